key_debounce_pulser: RTL and testbench
======================================

KEY_DEBOUNCE_PULSER -- requirements
Module: key_debounce_pulser

Upstream conditioning stage for the board's key inputs. It produces clean level, press, release and auto-repeat pulses that the counter, LED and display stages consume.

Interface
REQ-001 The block SHALL provide the following parameters:
- N_KEYS, default 8, number of keys.
- DEBOUNCE_CYCLES, default 270_000, stability window (10 ms at 27 MHz).
- REPEAT_DELAY_CYCLES, default 13_500_000, hold time before the first repeat (0.5 s).
- REPEAT_PERIOD_CYCLES, default 2_700_000, interval between repeats (0.1 s).
REQ-002 clock  input  1  system clock; all logic is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 key_raw  input  N_KEYS  raw, asynchronous, bouncing key levels; 1 = pressed.
REQ-005 repeat_en  input  1  enables auto-repeat pulses; sampled synchronously.
REQ-006 key_stable  output  N_KEYS  debounced key levels.
REQ-007 key_press  output  N_KEYS  one-cycle pulse per key on a debounced 0->1 transition.
REQ-008 key_release  output  N_KEYS  one-cycle pulse per key on a debounced 1->0 transition.
REQ-009 key_repeat  output  N_KEYS  one-cycle auto-repeat pulse per key.
REQ-010 any_pulse  output  1  OR of all bits of key_press and key_repeat.

Function
REQ-011 Each key_raw bit SHALL pass through a 2-flop synchronizer (sync1, then sync2) before any other logic uses it.
REQ-012 Each key SHALL have an independent debounce counter, width $clog2(DEBOUNCE_CYCLES).
- The counter clears on every edge where sync2 == key_stable.
- It increments on every edge where sync2 != key_stable.
REQ-013 When sync2 != key_stable and the counter == DEBOUNCE_CYCLES-1, key_stable SHALL take the value of sync2 and the counter SHALL clear, both on the same edge.
REQ-014 Latency: for a raw level held constant, key_stable SHALL change on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new level as the 1st.
REQ-015 Any raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL restart the count and SHALL NOT change key_stable.
REQ-016 key_press[i] and key_release[i] SHALL be registered outputs, high for exactly the one cycle in which key_stable[i] first shows its new value.
REQ-017 Each key SHALL have a repeat FSM with states IDLE, HOLD and REPEAT, and a repeat counter wide enough for max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES).
REQ-018 FSM transitions:
- IDLE -> HOLD on key_press, with the counter cleared.
- HOLD -> REPEAT when the counter == REPEAT_DELAY_CYCLES-1 and repeat_en = 1; a key_repeat pulse is emitted and the counter clears.
- REPEAT emits key_repeat and clears the counter each time the counter == REPEAT_PERIOD_CYCLES-1 and repeat_en = 1.
REQ-019 While repeat_en = 0, the FSM SHALL emit no key_repeat pulse and its counter SHALL saturate at the threshold. Repeating resumes on the first cycle after repeat_en returns to 1.
REQ-020 key_stable = 0 in HOLD or REPEAT SHALL force the FSM to IDLE on the same edge as key_release. No key_repeat pulse is permitted in that cycle, even if the threshold is reached simultaneously.
REQ-021 key_press and key_repeat for the same key SHALL never be high in the same cycle.
REQ-022 Keys SHALL be fully independent; simultaneous presses on several keys SHALL produce simultaneous per-key pulses.
REQ-023 any_pulse SHALL be registered, with the same timing as the key_press and key_repeat bits it ORs.
REQ-024 Each of the three cycle parameters SHALL be >= 2; the block SHALL reject smaller values at elaboration.

Reset
REQ-025 Asserting reset SHALL immediately clear:
- synchronizers
- key_stable, key_press, key_release, key_repeat, any_pulse
- all counters
- all FSMs, to IDLE
REQ-026 Reset mid-debounce or mid-repeat SHALL discard all progress. A key still held after reset deasserts SHALL be re-debounced from zero and SHALL produce a fresh key_press.
REQ-027 The first rising edge after reset deasserts SHALL be treated as a normal sampling edge.

Verification
Run with DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=5 and repeat_en=1, unless stated otherwise.
REQ-028 Clean press: key_raw[0] 0->1 held -> key_stable[0]=1 and key_press[0]=1 (one cycle) on the 6th edge; any_pulse=1 in that same cycle.
REQ-029 Bounce: key_raw[3] toggles 1,0,1,0 on consecutive cycles, then holds 1 -> no output change during the toggles; a single key_press[3] 6 edges after the final 0->1.
REQ-030 Auto-repeat: hold key 2 for 40 cycles after key_press[2] -> key_repeat[2] on cycles +10, +15, +20, ...; releasing gives exactly one key_release[2] and no further repeats.
REQ-031 repeat_en=0 during hold -> zero key_repeat pulses; raising repeat_en -> key_repeat on the next cycle, then every 5 cycles.
REQ-032 Multi-key: keys 0 and 7 pressed on the same edge -> key_press=8'h81 in one cycle and any_pulse=1 for exactly one cycle.
REQ-033 Reset mid-repeat: assert reset while key 1 is in REPEAT with key_raw held -> all outputs 0 immediately; after release of reset, key_press[1] on the 6th edge; first repeat 10 cycles later.

Source files
------------

// File: rtl/key_debounce_pulser.sv
// Key input conditioning: 2-flop synchronizer, per-key debounce, registered
// press/release pulses and a per-key hold/auto-repeat FSM.
module key_debounce_pulser #(
  parameter int N_KEYS               = 8,
  parameter int DEBOUNCE_CYCLES      = 270_000,
  parameter int REPEAT_DELAY_CYCLES  = 13_500_000,
  parameter int REPEAT_PERIOD_CYCLES = 2_700_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic              repeat_en,
  output logic [N_KEYS-1:0] key_stable,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              any_pulse
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 2 || REPEAT_PERIOD_CYCLES < 2) begin : g_bad_params
    $error("key_debounce_pulser: all cycle parameters must be >= 2");
  end

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_e;

  logic [N_KEYS-1:0] sync1, sync2;
  logic [N_KEYS-1:0] press_evt, release_evt, repeat_fire;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    rpt_state_e       state;
    logic             stable_q, press_q, release_q, repeat_q;
    logic             differs, flip;

    assign differs        = sync2[i] != stable_q;
    assign flip           = differs && (db_cnt == DB_LAST);
    assign press_evt[i]   = flip && sync2[i];
    assign release_evt[i] = flip && !sync2[i];
    // A release always wins over a repeat threshold reached on the same edge.
    assign repeat_fire[i] = repeat_en && !release_evt[i] &&
                            (((state == HOLD)   && (rpt_cnt == DELAY_LAST)) ||
                             ((state == REPEAT) && (rpt_cnt == PERIOD_LAST)));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        db_cnt    <= '0;
        stable_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= press_evt[i];
        release_q <= release_evt[i];
        if (!differs || flip) db_cnt <= '0;
        else                  db_cnt <= db_cnt + 1'b1;
        if (flip) stable_q <= sync2[i];
      end
    end

    // Counter saturates at its threshold while repeat_en is low.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state    <= IDLE;
        rpt_cnt  <= '0;
        repeat_q <= 1'b0;
      end else begin
        repeat_q <= repeat_fire[i];
        case (state)
          IDLE: begin
            if (press_evt[i]) begin
              state   <= HOLD;
              rpt_cnt <= '0;
            end
          end
          HOLD: begin
            if (release_evt[i]) begin
              state   <= IDLE;
              rpt_cnt <= '0;
            end else if (repeat_fire[i]) begin
              state   <= REPEAT;
              rpt_cnt <= '0;
            end else if (rpt_cnt != DELAY_LAST) begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (release_evt[i]) begin
              state   <= IDLE;
              rpt_cnt <= '0;
            end else if (repeat_fire[i]) begin
              rpt_cnt <= '0;
            end else if (rpt_cnt != PERIOD_LAST) begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            rpt_cnt <= '0;
          end
        endcase
      end
    end

    assign key_stable[i]  = stable_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_repeat[i]  = repeat_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) any_pulse <= 1'b0;
    else       any_pulse <= |(press_evt | repeat_fire);
  end

endmodule

// File: tb/tb_key_debounce_pulser.sv
// Scoreboard bench: stimulus pushes hand-computed output events with their
// cycle number; a negedge monitor pops one whenever the DUT shows a pulse.
module tb_key_debounce_pulser;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] key_raw;
  logic       repeat_en;
  logic [7:0] key_stable, key_press, key_release, key_repeat;
  logic       any_pulse;

  key_debounce_pulser #(
    .N_KEYS(8), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(5)
  ) dut (
    .clock(clock), .reset(reset), .key_raw(key_raw), .repeat_en(repeat_en),
    .key_stable(key_stable), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .any_pulse(any_pulse)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] press, rel, rpt, stable;
    logic       any;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_stable = '0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Events must be pushed in chronological order so the stable model tracks.
  task automatic push_ev(input int at, input logic [7:0] p, input logic [7:0] r, input logic [7:0] rp);
    ev_t e;
    model_stable = (model_stable | p) & ~r;
    e.cyc    = at;
    e.press  = p;
    e.rel    = r;
    e.rpt    = rp;
    e.stable = model_stable;
    e.any    = |(p | rp);
    exp_q.push_back(e);
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #2;
    end
  endtask

  always @(negedge clock) begin
    ev_t e;
    if (!reset && (((key_press | key_release | key_repeat) != 8'h00) || any_pulse)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse @cycle %0d: press=%h release=%h repeat=%h any=%b, expected no pulse",
                 cyc, key_press, key_release, key_repeat, any_pulse);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", 64'(cyc), 64'(e.cyc));
        check("event_outputs{press,release,repeat,stable,any}",
              64'({key_press, key_release, key_repeat, key_stable, any_pulse}),
              64'({e.press, e.rel, e.rpt, e.stable, e.any}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d events pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, r;
    reset     = 1'b0;
    key_raw   = '0;
    repeat_en = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("reset_outputs", 64'({key_stable, key_press, key_release, key_repeat, any_pulse}), 64'(0));
    goto_cycle(3);
    reset = 1'b0;
    goto_cycle(10);
    check("idle_after_reset", 64'({key_stable, key_press, key_release, key_repeat, any_pulse}), 64'(0));

    // Clean press on key 0; release lands on the edge the first repeat would fire.
    c = cyc;
    key_raw[0] = 1'b1;
    push_ev(c + 6,  8'h01, 8'h00, 8'h00);
    push_ev(c + 16, 8'h00, 8'h01, 8'h00);
    goto_cycle(c + 10);
    key_raw[0] = 1'b0;
    goto_cycle(c + 30);
    check("drained_clean_press", 64'(exp_q.size()), 64'(0));

    // Bounce on key 3: 1,0,1,0 then hold 1.
    c = cyc;
    key_raw[3] = 1'b1;
    goto_cycle(c + 1); key_raw[3] = 1'b0;
    goto_cycle(c + 2); key_raw[3] = 1'b1;
    goto_cycle(c + 3); key_raw[3] = 1'b0;
    goto_cycle(c + 4); key_raw[3] = 1'b1;
    push_ev(c + 10, 8'h08, 8'h00, 8'h00);
    push_ev(c + 18, 8'h00, 8'h08, 8'h00);
    goto_cycle(c + 12);
    key_raw[3] = 1'b0;
    goto_cycle(c + 30);
    check("drained_bounce", 64'(exp_q.size()), 64'(0));

    // Auto-repeat on key 2, held 40 cycles past the press.
    c = cyc;
    key_raw[2] = 1'b1;
    push_ev(c + 6, 8'h04, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) push_ev(c + 16 + 5 * k, 8'h00, 8'h00, 8'h04);
    push_ev(c + 52, 8'h00, 8'h04, 8'h00);
    goto_cycle(c + 46);
    key_raw[2] = 1'b0;
    goto_cycle(c + 70);
    check("drained_auto_repeat", 64'(exp_q.size()), 64'(0));

    // Key 4 held with repeat_en low, then enabled late.
    c = cyc;
    key_raw[4] = 1'b1;
    repeat_en  = 1'b0;
    push_ev(c + 6,  8'h10, 8'h00, 8'h00);
    push_ev(c + 37, 8'h00, 8'h00, 8'h10);
    push_ev(c + 42, 8'h00, 8'h00, 8'h10);
    push_ev(c + 47, 8'h00, 8'h00, 8'h10);
    push_ev(c + 51, 8'h00, 8'h10, 8'h00);
    goto_cycle(c + 36);
    repeat_en = 1'b1;
    goto_cycle(c + 45);
    key_raw[4] = 1'b0;
    goto_cycle(c + 65);
    check("drained_repeat_en", 64'(exp_q.size()), 64'(0));

    // Keys 0 and 7 together.
    c = cyc;
    key_raw = 8'h81;
    push_ev(c + 6,  8'h81, 8'h00, 8'h00);
    push_ev(c + 14, 8'h00, 8'h81, 8'h00);
    goto_cycle(c + 8);
    key_raw = 8'h00;
    goto_cycle(c + 30);
    check("drained_multi_key", 64'(exp_q.size()), 64'(0));

    // Reset while key 1 is repeating; the held key must be re-debounced.
    c = cyc;
    key_raw[1] = 1'b1;
    push_ev(c + 6,  8'h02, 8'h00, 8'h00);
    push_ev(c + 16, 8'h00, 8'h00, 8'h02);
    push_ev(c + 21, 8'h00, 8'h00, 8'h02);
    goto_cycle(c + 23);
    reset = 1'b1;
    #1;
    check("reset_mid_repeat", 64'({key_stable, key_press, key_release, key_repeat, any_pulse}), 64'(0));
    check("drained_before_reset", 64'(exp_q.size()), 64'(0));
    model_stable = '0;
    goto_cycle(c + 26);
    reset = 1'b0;
    r = cyc;
    push_ev(r + 6,  8'h02, 8'h00, 8'h00);
    push_ev(r + 16, 8'h00, 8'h00, 8'h02);
    push_ev(r + 21, 8'h00, 8'h00, 8'h02);
    push_ev(r + 24, 8'h00, 8'h02, 8'h00);
    goto_cycle(r + 18);
    key_raw[1] = 1'b0;
    goto_cycle(r + 40);
    check("drained_after_reset", 64'(exp_q.size()), 64'(0));
    check("final_stable", 64'(key_stable), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
